fetch_pipe_ctrl: RTL

- Consumer end of the hazard-control interface: it takes stall_IFID, stall_IDEX, flush and the 32-bit hazard code, and applies them to the PC register and the IF/ID pipeline register.
- Drives a registered bubble request into the ID/EX register.
- Keeps stall and flush statistics, the last hazard code, and a stall-length watchdog for debug.
- Sits between instruction memory (addressed combinationally by pc_IF) and the decode stage.

---
 rtl/fetch_pipe_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC and IF/ID register control driven by hazard unit.
// Applies stall/flush, issues ID/EX bubbles, keeps hazard debug stats.
module fetch_pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_IFID,
  input  logic        stall_IDEX,
  input  logic        flush,
  input  logic [31:0] stall_code,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_IF,
  output logic [31:0] pc_IF,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic        bubble_EX,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [3:0]  last_code,
  output logic        illegal_code,
  output logic        stall_timeout
);

  localparam logic [7:0]  RUN_LIM = 8'(MAX_STALL);
  localparam logic [7:0]  RUN_MAX = 8'hFF;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  if_id_t      if_id_q;
  if_id_t      if_id_d;
  logic [31:0] pc_d;
  logic [7:0]  run_q;
  logic [7:0]  run_d;
  logic        do_flush;
  logic        do_stall;
  logic        code_ok;

  assign do_flush = flush;
  assign do_stall = stall_IFID & ~flush;

  assign pc_ID    = if_id_q.pc;
  assign instr_ID = if_id_q.instr;
  assign valid_ID = if_id_q.valid;

  // Next fetch PC and IF/ID contents: flush > stall > advance
  always_comb begin
    pc_d    = pc_IF;
    if_id_d = if_id_q;
    unique case (1'b1)
      do_flush: begin
        pc_d    = {branch_target[31:2], 2'b00};
        if_id_d = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
      end
      do_stall: begin
        pc_d    = pc_IF;
        if_id_d = if_id_q;
      end
      default: begin
        pc_d    = pc_IF + 32'd4;
        if_id_d = '{pc: pc_IF, instr: instr_IF, valid: 1'b1};
      end
    endcase
  end

  // Hazard code legality
  always_comb begin
    code_ok = 1'b0;
    case (stall_code)
      32'h0, 32'h1, 32'hA, 32'hB, 32'hF: code_ok = 1'b1;
      default:                           code_ok = 1'b0;
    endcase
  end

  // Stall-run length for the watchdog, saturating
  always_comb begin
    run_d = 8'h0;
    if (do_stall)
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 8'd1;
  end

  // Fetch PC, IF/ID register and bubble request
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_IF     <= RESET_PC;
      if_id_q   <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
      bubble_EX <= 1'b1;
    end else begin
      pc_IF     <= pc_d;
      if_id_q   <= if_id_d;
      bubble_EX <= flush | stall_IDEX;
    end
  end

  // Saturating stall/flush statistics
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= 32'h0;
      flush_count <= 32'h0;
    end else begin
      if (do_stall && stall_count != CNT_MAX)
        stall_count <= stall_count + 32'd1;
      if (do_flush && flush_count != CNT_MAX)
        flush_count <= flush_count + 32'd1;
    end
  end

  // Hazard code capture and sticky illegal flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_code    <= 4'h0;
      illegal_code <= 1'b0;
    end else begin
      if (stall_code != 32'h0)
        last_code <= stall_code[3:0];
      if (!code_ok)
        illegal_code <= 1'b1;
    end
  end

  // Stall watchdog, sticky until reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q         <= 8'h0;
      stall_timeout <= 1'b0;
    end else begin
      run_q <= run_d;
      if (do_stall && run_d == RUN_LIM)
        stall_timeout <= 1'b1;
    end
  end

endmodule
